// File: rtl/cla_acc_18bit_pkg.sv
// Shared types and constants for the 18-bit carry-lookahead frame accumulator.
// Also holds the lookahead carry function used inside the adder.
package cla_acc_18bit_pkg;

  localparam int unsigned DATA_W    = 18;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned LA_W      = 5;   // bits per lookahead group
  localparam int unsigned GRP_N     = 4;   // groups covering the padded operand
  localparam int unsigned PAD_W     = LA_W * GRP_N;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              ovf;
  } acc_t;

  // Flat lookahead: every carry is an explicit sum of generate/propagate products.
  function automatic logic [LA_W:0] lookahead(input logic [LA_W-1:0] g,
                                              input logic [LA_W-1:0] p,
                                              input logic            cin);
    logic [LA_W:0] c;
    logic          term;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 1; i <= LA_W; i++) begin
      term = cin;
      for (int unsigned k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_acc_18bit_cla.sv
// Two-level carry-lookahead adder: 18-bit operands, 19-bit result including carry-out.
// Operands are zero-padded to PAD_W so every lookahead group has the same width.
module cla_18bit
  import cla_acc_18bit_pkg::*;
(
  input  logic [DATA_W-1:0] i_add1,
  input  logic [DATA_W-1:0] i_add2,
  output logic [DATA_W:0]   o_result
);

  logic [PAD_W-1:0] a;
  logic [PAD_W-1:0] b;
  logic [PAD_W-1:0] g;
  logic [PAD_W-1:0] p;
  logic [PAD_W-1:0] c;
  logic [GRP_N-1:0] grp_g;
  logic [GRP_N-1:0] grp_p;
  logic [LA_W:0]    grp_c;
  logic             unused_carry;

  assign a = PAD_W'(i_add1);
  assign b = PAD_W'(i_add2);
  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, each group evaluated with zero carry-in.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int unsigned k = 0; k < GRP_N; k++) begin
      grp_g[k] = 1'(lookahead(g[k*LA_W +: LA_W], p[k*LA_W +: LA_W], 1'b0) >> LA_W);
      grp_p[k] = &p[k*LA_W +: LA_W];
    end
  end

  assign grp_c = lookahead(LA_W'(grp_g), LA_W'(grp_p), 1'b0);

  // Bit carries inside each group, seeded by the group-level carry-in.
  always_comb begin
    c = '0;
    for (int unsigned k = 0; k < GRP_N; k++) begin
      c[k*LA_W +: LA_W] = LA_W'(lookahead(g[k*LA_W +: LA_W], p[k*LA_W +: LA_W], grp_c[k]));
    end
  end

  // Padded bits have g=p=0, so the carry into bit DATA_W is the true carry-out.
  assign o_result = {c[DATA_W], p[DATA_W-1:0] ^ c[DATA_W-1:0]};

  assign unused_carry = ^{c[PAD_W-1], grp_c[LA_W:GRP_N], a[PAD_W-1:DATA_W], b[PAD_W-1:DATA_W]};

endmodule

// File: rtl/cla_acc_18bit.sv
// Frame accumulator: sums accepted samples through a CLA, reports sum/overflow/count
// per frame and holds the result until the consumer takes it.
module cla_acc_18bit
  import cla_acc_18bit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf,
  output logic [CNT_W-1:0]  o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  acc_t             run;
  acc_t             res;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] res_count;
  logic [DATA_W:0]  sum;
  logic             accept;
  logic             handshake;

  cla_18bit u_cla (
    .i_add1   (run.sum),
    .i_add2   (i_data),
    .o_result (sum)
  );

  assign accept    = i_valid && o_ready;
  assign handshake = o_valid && i_ready;
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

  assign o_sum   = res.sum;
  assign o_ovf   = res.ovf;
  assign o_count = res_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && i_last) state_next = HOLD;
      HOLD:    if (handshake)        state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      o_ready <= (state_next == ACCUM);
      o_valid <= (state_next == HOLD);
    end
  end

  // Running accumulator is cleared only when the held result is consumed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run       <= '0;
      count     <= '0;
      res       <= '0;
      res_count <= '0;
    end else if (handshake) begin
      run   <= '0;
      count <= '0;
    end else if (accept) begin
      run.sum <= sum[DATA_W-1:0];
      run.ovf <= run.ovf | sum[DATA_W];
      count   <= count_inc;
      if (i_last) begin
        res.sum   <= sum[DATA_W-1:0];
        res.ovf   <= run.ovf | sum[DATA_W];
        res_count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_cla_acc_18bit.sv
// Self-checking bench for cla_acc_18bit: arithmetic reference model compared every
// cycle, plus literal result checks for the directed frames.
module tb_cla_acc_18bit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MOD     = 1 << 18;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [17:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              out_ready;
  logic              out_valid;
  logic              cons_ready = 1'b1;
  logic [17:0]       out_sum;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_count;

  int n_checks = 0;
  int n_fail   = 0;

  cla_acc_18bit #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .i_data  (in_data),
    .i_last  (in_last),
    .o_ready (out_ready),
    .o_valid (out_valid),
    .i_ready (cons_ready),
    .o_sum   (out_sum),
    .o_ovf   (out_ovf),
    .o_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: frame result computed with plain integer arithmetic.
  bit m_started = 0;
  bit m_pending = 0;
  int m_acc = 0, m_cnt = 0;
  bit m_ovf = 0;
  int m_rsum = 0, m_rcnt = 0;
  bit m_rovf = 0;

  always @(posedge clk) begin
    int s;
    m_started = 1;
    if (rst) begin
      m_pending = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
      m_rsum = 0; m_rcnt = 0; m_rovf = 0;
    end else if (m_pending) begin
      if (cons_ready) begin
        m_pending = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
      end
    end else if (in_valid) begin
      s = m_acc + int'(in_data);
      if (s >= MOD) m_ovf = 1;
      m_acc = s % MOD;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (in_last) begin
        m_rsum = m_acc; m_rovf = m_ovf; m_rcnt = m_cnt; m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("ready", int'(out_ready), int'(!m_pending));
      check("valid", int'(out_valid), int'(m_pending));
      if (m_pending) begin
        check("model_sum",   int'(out_sum),   m_rsum);
        check("model_ovf",   int'(out_ovf),   int'(m_rovf));
        check("model_count", int'(out_count), m_rcnt);
      end
    end
  end

  // Offer one sample and hold it until it is accepted; inputs change 1ns after the edge.
  task automatic send(input logic [17:0] data, input logic last);
    bit taken = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      taken = out_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input int sum, input int ovf, input int cnt);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check({name, "_valid"}, int'(seen), 1);
    if (seen) begin
      check({name, "_sum"},   int'(out_sum),   sum);
      check({name, "_ovf"},   int'(out_ovf),   ovf);
      check({name, "_count"}, int'(out_count), cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(out_ready), 1);
    check("reset_valid", int'(out_valid), 0);
    check("reset_sum",   int'(out_sum),   0);
    check("reset_count", int'(out_count), 0);
    @(posedge clk);
    #1;

    send(18'h00010, 1'b0);
    send(18'h00020, 1'b0);
    send(18'h00030, 1'b1);
    idle();
    expect_result("three", 'h00060, 0, 3);

    send(18'h3FFFF, 1'b0);
    send(18'h00001, 1'b1);
    idle();
    expect_result("wrap", 'h00000, 1, 2);

    send(18'h2AAAA, 1'b1);
    idle();
    expect_result("single", 'h2AAAA, 0, 1);

    // Consumer stalls while upstream keeps offering a sample.
    cons_ready = 1'b0;
    send(18'h00007, 1'b1);
    in_valid = 1'b1;
    in_data  = 18'h00100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", int'(out_ready), 0);
      check("stall_sum",   int'(out_sum),   'h00007);
      check("stall_count", int'(out_count), 1);
      @(posedge clk);
      #1;
    end
    cons_ready = 1'b1;
    send(18'h00100, 1'b1);
    idle();
    expect_result("after_stall", 'h00100, 0, 1);

    for (int i = 0; i < 300; i++) send(18'h00001, (i == 299));
    idle();
    expect_result("saturate", 'h0012C, 0, CNT_MAX);

    send(18'h00001, 1'b0);
    send(18'h00002, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(out_ready), 1);
    check("abort_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    send(18'h00005, 1'b1);
    idle();
    expect_result("abort", 'h00005, 0, 1);

    // Frame with a gap in i_valid and a carry-out in the middle.
    send(18'h20000, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    send(18'h20000, 1'b0);
    send(18'h00123, 1'b1);
    idle();
    expect_result("gap", 'h00123, 1, 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_acc_18bit.md
CLA_ACC_18BIT -- requirements
Module: cla_acc_18bit

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the per-frame sample counter.
REQ-002 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_valid  input  1  SHALL qualify i_data/i_last as a sample offer.
REQ-005 i_data  input  18  SHALL carry the unsigned sample to accumulate.
REQ-006 i_last  input  1  SHALL mark the final sample of a frame.
REQ-007 o_ready  output  1  SHALL indicate the block accepts a sample this cycle.
REQ-008 o_valid  output  1  SHALL qualify the frame result outputs.
REQ-009 i_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-010 o_sum  output  18  SHALL carry the frame sum modulo 2^18.
REQ-011 o_ovf  output  1  SHALL be a sticky flag: some addition in the frame produced carry-out.
REQ-012 o_count  output  CNT_W  SHALL carry the number of samples in the frame, saturating.

Function
REQ-013 A sample SHALL be accepted exactly when i_valid && o_ready in the same cycle.
REQ-014 FSM SHALL have two states: ACCUM (o_ready=1, o_valid=0) and HOLD (o_ready=0, o_valid=1).
REQ-015 In ACCUM, each accepted sample SHALL update acc <= sum[17:0], ovf <= ovf | sum[18], where sum = acc + i_data (19-bit, via the CLA).
REQ-016 Each accepted sample SHALL increment the counter; at 2^CNT_W-1 it SHALL hold (saturate).
REQ-017 Accepted sample with i_last=1 SHALL load o_sum/o_ovf/o_count with the post-update values and move to HOLD; o_valid SHALL assert the next cycle (latency 1).
REQ-018 Single-sample frame (i_last on first sample) SHALL yield o_sum=i_data, o_ovf=0, o_count=1.
REQ-019 In HOLD, o_sum/o_ovf/o_count SHALL stay stable until o_valid && i_ready.
REQ-020 On o_valid && i_ready, state SHALL return to ACCUM next cycle with acc=0, ovf=0, count=0; no sample SHALL be accepted in that handshake cycle.
REQ-021 i_valid with o_ready=0 SHALL be ignored with no state change; upstream holds the sample.
REQ-022 i_data/i_last SHALL be don't-care when i_valid=0.
REQ-023 The 18-bit add SHALL be performed combinationally by one carry-lookahead adder instance; no other adder on the accumulate path.

Reset
REQ-024 With i_rst=1 at a clock edge: state=ACCUM, acc=0, ovf=0, count=0, o_valid=0, o_sum=0, o_ovf=0, o_count=0.
REQ-025 Reset mid-frame or in HOLD SHALL discard the partial frame or pending result; no result emitted.
REQ-026 o_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 Shared package SHALL hold DATA_W=18, the FSM state enum {ACCUM, HOLD}, and the default CNT_W.
REQ-028 Single sub-module: cla_18bit (ports i_add1, i_add2, o_result[18:0]) with i_add1=acc, i_add2=i_data.
REQ-029 All registers SHALL be in the top; sub-module purely combinational.

Verification
REQ-030 Frame 0x00010, 0x00020, 0x00030 (last), i_ready=1 -> one cycle after last: o_valid=1, o_sum=0x00060, o_ovf=0, o_count=3.
REQ-031 Frame 0x3FFFF, 0x00001 (last) -> o_sum=0x00000, o_ovf=1, o_count=2.
REQ-032 Single sample 0x2AAAA with i_last -> o_sum=0x2AAAA, o_ovf=0, o_count=1.
REQ-033 Result pending, i_ready=0 for 5 cycles with i_valid=1 -> o_ready=0, outputs stable, no sample accepted; after i_ready=1, next frame starts from acc=0.
REQ-034 300 samples of 0x00001 (CNT_W=8) -> o_count=255, o_sum=0x0012C, o_ovf=0.
REQ-035 i_rst pulsed after 2 of 3 samples, then frame 0x00005 (last) -> o_sum=0x00005, o_count=1; no result for the aborted frame.
